// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station: holds ALU ops, snoops the CDB for operands,
// issues the lowest-index ready entry through a registered port
module rs_issue_queue #(
  parameter int XLEN      = 32,
  parameter int ROB_WIDTH = 4,
  parameter int RS_LOG    = 3,
  parameter int CDB_CH    = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        dp_en,
  input  logic [6:0]                  dp_op,
  input  logic [3:0]                  dp_funct,
  input  logic [XLEN-1:0]             dp_pc,
  input  logic [ROB_WIDTH:0]          dp_qj,
  input  logic [ROB_WIDTH:0]          dp_qk,
  input  logic [XLEN-1:0]             dp_vj,
  input  logic [XLEN-1:0]             dp_vk,
  input  logic [XLEN-1:0]             dp_imm,
  input  logic [ROB_WIDTH-1:0]        dp_rob_idx,
  output logic                        rs_full,
  output logic [RS_LOG:0]             rs_count,
  input  logic [CDB_CH-1:0]           cdb_en,
  input  logic [CDB_CH*ROB_WIDTH-1:0] cdb_rob_idx,
  input  logic [CDB_CH*XLEN-1:0]      cdb_value,
  output logic                        alu_en,
  output logic [6:0]                  alu_op,
  output logic [3:0]                  alu_funct,
  output logic [XLEN-1:0]             alu_pc,
  output logic [XLEN-1:0]             alu_vj,
  output logic [XLEN-1:0]             alu_vk,
  output logic [XLEN-1:0]             alu_imm,
  output logic [ROB_WIDTH-1:0]        alu_rob_idx
);

  localparam int RS_DEPTH = 1 << RS_LOG;
  localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

  // Returns {hit, value}; scanning downward lets the lowest channel win on multiple hits.
  function automatic logic [XLEN:0] snoop(
    input logic [ROB_WIDTH:0]          tag,
    input logic [CDB_CH-1:0]           en,
    input logic [CDB_CH*ROB_WIDTH-1:0] idx,
    input logic [CDB_CH*XLEN-1:0]      val
  );
    logic [XLEN:0] r;
    r = '0;
    for (int c = CDB_CH - 1; c >= 0; c--) begin
      if (!tag[ROB_WIDTH] && en[c] && (idx[c*ROB_WIDTH +: ROB_WIDTH] == tag[ROB_WIDTH-1:0]))
        r = {1'b1, val[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [RS_DEPTH-1:0]  busy;
  logic [6:0]           op_q    [RS_DEPTH];
  logic [3:0]           funct_q [RS_DEPTH];
  logic [XLEN-1:0]      pc_q    [RS_DEPTH];
  logic [ROB_WIDTH:0]   qj_q    [RS_DEPTH];
  logic [ROB_WIDTH:0]   qk_q    [RS_DEPTH];
  logic [XLEN-1:0]      vj_q    [RS_DEPTH];
  logic [XLEN-1:0]      vk_q    [RS_DEPTH];
  logic [XLEN-1:0]      imm_q   [RS_DEPTH];
  logic [ROB_WIDTH-1:0] rob_q   [RS_DEPTH];

  logic [RS_DEPTH-1:0]  ready;
  logic [RS_LOG-1:0]    free_idx;
  logic [RS_LOG-1:0]    sel_idx;
  logic                 alloc;
  logic                 issue;
  logic [XLEN:0]        byp_j;
  logic [XLEN:0]        byp_k;
  logic [XLEN:0]        wake_j  [RS_DEPTH];
  logic [XLEN:0]        wake_k  [RS_DEPTH];

  always_comb begin
    ready    = '0;
    free_idx = '0;
    sel_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      ready[i] = busy[i] && (qj_q[i] == NON_DEP) && (qk_q[i] == NON_DEP);
      if (!busy[i])
        free_idx = RS_LOG'(i);
      if (ready[i])
        sel_idx = RS_LOG'(i);
    end
  end

  // Full is judged on registered busy bits only, so a slot freed by issue waits a cycle.
  assign rs_full = &busy;
  assign alloc   = dp_en && !rs_full;
  assign issue   = |ready;
  assign byp_j   = snoop(dp_qj, cdb_en, cdb_rob_idx, cdb_value);
  assign byp_k   = snoop(dp_qk, cdb_en, cdb_rob_idx, cdb_value);

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_wake
    assign wake_j[g] = snoop(qj_q[g], cdb_en, cdb_rob_idx, cdb_value);
    assign wake_k[g] = snoop(qk_q[g], cdb_en, cdb_rob_idx, cdb_value);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy        <= '0;
      rs_count    <= '0;
      alu_en      <= 1'b0;
      alu_op      <= '0;
      alu_funct   <= '0;
      alu_pc      <= '0;
      alu_vj      <= '0;
      alu_vk      <= '0;
      alu_imm     <= '0;
      alu_rob_idx <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy     <= '0;
        rs_count <= '0;
        alu_en   <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy[i] && wake_j[i][XLEN]) begin
            qj_q[i] <= NON_DEP;
            vj_q[i] <= wake_j[i][XLEN-1:0];
          end
          if (busy[i] && wake_k[i][XLEN]) begin
            qk_q[i] <= NON_DEP;
            vk_q[i] <= wake_k[i][XLEN-1:0];
          end
        end

        alu_en <= issue;
        if (issue) begin
          busy[sel_idx] <= 1'b0;
          alu_op        <= op_q[sel_idx];
          alu_funct     <= funct_q[sel_idx];
          alu_pc        <= pc_q[sel_idx];
          alu_vj        <= vj_q[sel_idx];
          alu_vk        <= vk_q[sel_idx];
          alu_imm       <= imm_q[sel_idx];
          alu_rob_idx   <= rob_q[sel_idx];
        end

        // free_idx is never busy, so it cannot collide with the issuing slot.
        if (alloc) begin
          busy[free_idx]    <= 1'b1;
          op_q[free_idx]    <= dp_op;
          funct_q[free_idx] <= dp_funct;
          pc_q[free_idx]    <= dp_pc;
          imm_q[free_idx]   <= dp_imm;
          rob_q[free_idx]   <= dp_rob_idx;
          qj_q[free_idx]    <= byp_j[XLEN] ? NON_DEP : dp_qj;
          vj_q[free_idx]    <= byp_j[XLEN] ? byp_j[XLEN-1:0] : dp_vj;
          qk_q[free_idx]    <= byp_k[XLEN] ? NON_DEP : dp_qk;
          vk_q[free_idx]    <= byp_k[XLEN] ? byp_k[XLEN-1:0] : dp_vk;
        end

        rs_count <= rs_count + (RS_LOG+1)'(alloc) - (RS_LOG+1)'(issue);
      end
    end
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised reservation station for the out-of-order core. Sits between the dispatcher and the integer ALU.
- Holds up to RS_DEPTH in-flight ALU ops and snoops CDB_CH result broadcast channels for operand wakeup.
- Selects the lowest-index ready entry each cycle and issues it to the ALU through a registered output.
- Supports a global flush on branch misprediction and reports occupancy to the dispatcher.

Parameters:
- XLEN, 32, operand/pc/imm width
- ROB_WIDTH, 4, ROB index width; tag NON_DEP = 1<<ROB_WIDTH (MSB set) means no dependency
- RS_LOG, 3, log2 of entry count; RS_DEPTH = 1<<RS_LOG
- CDB_CH, 2, number of CDB snoop channels (ALU, LSB, ...)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global stall; when low, all state holds and no outputs change
- flush_in  in  1  misprediction flush from ROB
- dp_en  in  1  dispatch valid
- dp_op  in  7  opcode
- dp_funct  in  4  {funct7[5],funct3}
- dp_pc  in  XLEN  instruction pc
- dp_qj / dp_qk  in  ROB_WIDTH+1  source tags
- dp_vj / dp_vk  in  XLEN  source values
- dp_imm  in  XLEN  immediate
- dp_rob_idx  in  ROB_WIDTH  destination ROB index
- rs_full  out  1  combinational: no free entry
- rs_count  out  RS_LOG+1  registered occupancy
- cdb_en  in  CDB_CH  per-channel broadcast valid
- cdb_rob_idx  in  CDB_CH*ROB_WIDTH  channel c at bits [c*ROB_WIDTH +: ROB_WIDTH]
- cdb_value  in  CDB_CH*XLEN  channel c at bits [c*XLEN +: XLEN]
- alu_en  out  1  registered issue valid
- alu_op, alu_funct, alu_pc, alu_vj, alu_vk, alu_imm, alu_rob_idx  out  matching widths  issued entry fields

Behaviour:
- Reset (rst_in=1 at posedge): all busy cleared, rs_count=0, alu_en=0, all alu_* data outputs 0. Reset has priority over flush and rdy_in.
- rdy_in=0: no allocation, wakeup, issue or count change. Outputs hold. Allocation and CDB inputs presented while rdy_in=0 are lost.
- Allocation: when dp_en && !rs_full, write the lowest-index non-busy entry and set busy. The dispatcher must not assert dp_en while rs_full; if it does, the request is ignored.
- Dispatch-time bypass: for each of qj/qk whose MSB=0, if any cdb_en[c] with cdb_rob_idx[c]==tag[ROB_WIDTH-1:0], store tag=NON_DEP and value=cdb_value[c]. If several channels match, the lowest c wins.
- Wakeup: every cycle, each busy entry with a pending Q matching an enabled CDB channel takes NON_DEP and the broadcast value. Same lowest-c priority applies.
- Ready: busy && qj==NON_DEP && qk==NON_DEP, evaluated on current registered state. Values woken this cycle become ready next cycle. An entry allocated this cycle is not issuable until next cycle.
- Issue: if any ready entry exists, the lowest index is selected. Its fields go to alu_* at the next posedge with alu_en=1, and its busy is cleared in the same edge. Otherwise alu_en=0 next cycle. Throughput is 1 issue/cycle; latency from entry-ready to alu_en is 1 cycle.
- Simultaneous alloc + issue: allowed. The freed slot is not reusable until the following cycle, so rs_full is computed from current busy bits only.
- rs_count next = count + alloc − issue.
- flush_in=1 (rdy_in=1): all busy cleared, rs_count=0, alu_en=0 next cycle. Allocation and issue that cycle are suppressed.
- Full boundary: rs_full=1 exactly when all RS_DEPTH entries are busy. Empty: rs_count=0, alu_en stays 0.
- Tags are compared on the ROB_WIDTH LSBs only when the MSB is 0. A NON_DEP tag never matches.

Test Plan:
- Reset then dispatch op=0110011, qj=qk=NON_DEP, vj=5, vk=7, rob=3 -> cycle+2: alu_en=1, alu_vj=5, alu_vk=7, alu_rob_idx=3; cycle+3 alu_en=0, rs_count=0.
- Dispatch qj=2 (dep), vk=9; two cycles later cdb_en=01, idx0=2, value0=0x100 -> alu_en one cycle after wakeup with alu_vj=0x100.
- Dispatch qj=4 while the same cycle cdb_en=10, idx1=4, value1=0xABC -> entry stores vj=0xABC; issues next cycle with no wait.
- Fill all 8 entries with unresolved deps -> rs_full=1, rs_count=8; further dp_en ignored; broadcast wakes entries 5 and 2 in the same cycle -> entry 2 issues first, then 5; rs_full drops.
- With 3 busy entries, assert flush_in for 1 cycle alongside dp_en -> rs_count=0, alu_en=0, nothing issues afterwards, even on matching CDB broadcast.
- Hold rdy_in=0 for 3 cycles with a ready entry -> alu_en and rs_count frozen; issue occurs the cycle after rdy_in returns high.
